// File: rtl/bcd_pkg.sv
// Shared types and constants for the push-button BCD editor.
// Holds the digit type, key indices, debouncer states and digit step helpers.
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  localparam int KEY_CURSOR = 0;
  localparam int KEY_INC    = 1;
  localparam int KEY_DEC    = 2;
  localparam int KEY_COMMIT = 3;
  localparam int NUM_KEYS   = 4;

  typedef enum logic {
    DB_RELEASED = 1'b0,
    DB_PRESSED  = 1'b1
  } db_state_e;

  // Digits wrap within 0..9; there is no carry or borrow into neighbours.
  function automatic bcd_t bcd_inc(input bcd_t d);
    return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic bcd_t bcd_dec(input bcd_t d);
    return (d == 4'd0) ? BCD_MAX : d - 4'd1;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes and debounces one active-low push button.
// Emits a single-cycle pulse on each accepted released->pressed transition.
module key_debouncer
  import bcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       r_sync;
  db_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pressed;

  db_state_e        w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_pressed_next;
  logic             w_level;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, which is what makes r_sync a real 2-stage chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync    <= 2'b11;
      r_state   <= DB_RELEASED;
      r_cnt     <= '0;
      r_pressed <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], key_n};
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_pressed <= w_pressed_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = '0;
    w_pressed_next = 1'b0;
    w_level        = (r_state == DB_RELEASED);
    if (r_sync[1] != w_level) begin
      // The counter only runs while the synchronized level disagrees.
      if (r_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
        w_state_next   = (r_state == DB_RELEASED) ? DB_PRESSED : DB_RELEASED;
        w_pressed_next = (r_state == DB_RELEASED);
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end
  end

  assign pressed = r_pressed;
  assign level   = w_level;

endmodule

// File: rtl/bcd_key_entry.sv
// Four-key editor for a BCD_NUM-digit value: move cursor, inc/dec the
// selected digit, and commit the value to a loadable counter with a strobe.
module bcd_key_entry
  import bcd_pkg::*;
#(
  parameter int BCD_NUM     = 8,
  parameter int CLK_FREQ_MZ = 50,
  parameter int DEBOUNCE_US = 10000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_KEYS-1:0]        keys_n,
  output bcd_t                       bcds      [BCD_NUM],
  output logic [$clog2(BCD_NUM)-1:0] cursor,
  output logic                       load,
  output bcd_t                       load_bcds [BCD_NUM]
);

  localparam int DEBOUNCE_CYCLES = CLK_FREQ_MZ * DEBOUNCE_US;
  localparam int CUR_W           = $clog2(BCD_NUM);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("bcd_key_entry: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [NUM_KEYS-1:0] w_pressed;
  logic [NUM_KEYS-1:0] w_level;
  logic                w_inc;
  logic                w_dec;

  bcd_t             r_bcds      [BCD_NUM];
  bcd_t             r_load_bcds [BCD_NUM];
  logic [CUR_W-1:0] r_cursor;
  logic             r_load;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk    (clk),
      .reset  (reset),
      .key_n  (keys_n[k]),
      .pressed(w_pressed[k]),
      .level  (w_level[k])
    );

    a_pulse_while_held: assert property (
      @(posedge clk) disable iff (reset) w_pressed[k] |-> !w_level[k]
    );
  end

  // Increment and decrement in the same cycle cancel each other.
  assign w_inc = w_pressed[KEY_INC] & ~w_pressed[KEY_DEC];
  assign w_dec = w_pressed[KEY_DEC] & ~w_pressed[KEY_INC];

  // NOTE: the digit arrays are a handful of flops, not a RAM, so they take
  // the async reset like any other register and come up as a known value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BCD_NUM; i++) begin
        r_bcds[i]      <= '0;
        r_load_bcds[i] <= '0;
      end
      r_cursor <= '0;
      r_load   <= 1'b0;
    end else begin
      // Edits land on the old cursor; commit captures the pre-edit digits.
      if (w_inc) r_bcds[r_cursor] <= bcd_inc(r_bcds[r_cursor]);
      if (w_dec) r_bcds[r_cursor] <= bcd_dec(r_bcds[r_cursor]);
      if (w_pressed[KEY_CURSOR]) begin
        r_cursor <= (r_cursor == CUR_W'(BCD_NUM - 1)) ? '0 : r_cursor + CUR_W'(1);
      end
      if (w_pressed[KEY_COMMIT]) r_load_bcds <= r_bcds;
      r_load <= w_pressed[KEY_COMMIT];
    end
  end

  assign bcds      = r_bcds;
  assign load_bcds = r_load_bcds;
  assign cursor    = r_cursor;
  assign load      = r_load;

endmodule

// File: tb/tb_bcd_key_entry.sv
// Directed bench for bcd_key_entry with DEBOUNCE_CYCLES = 4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bcd_key_entry;
  import bcd_pkg::*;

  localparam int N   = 8;
  localparam int D   = 4;
  localparam int LAT = D + 3;

  localparam logic [3:0] M_CUR = 4'b0001;
  localparam logic [3:0] M_INC = 4'b0010;
  localparam logic [3:0] M_DEC = 4'b0100;
  localparam logic [3:0] M_COM = 4'b1000;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] keys_n;
  bcd_t       bcds      [N];
  logic [2:0] cursor;
  logic       load;
  bcd_t       load_bcds [N];

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  bcd_t exp_bcds  [N];
  bcd_t exp_load  [N];
  int   exp_cursor;

  always #5 clk = ~clk;

  bcd_key_entry #(
    .BCD_NUM    (N),
    .CLK_FREQ_MZ(1),
    .DEBOUNCE_US(D)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .keys_n   (keys_n),
    .bcds     (bcds),
    .cursor   (cursor),
    .load     (load),
    .load_bcds(load_bcds)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] mask, input int low_n, input int high_n);
    keys_n = ~mask;
    tick(low_n);
    keys_n = 4'hF;
    tick(high_n);
  endtask

  task automatic set_digit(input int idx, input int target);
    while (exp_cursor != idx) begin
      press(M_CUR, 10, 10);
      exp_cursor = (exp_cursor + 1) % N;
    end
    repeat ((target - int'(exp_bcds[idx]) + 10) % 10) press(M_INC, 10, 10);
    exp_bcds[idx] = bcd_t'(target);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    keys_n = 4'hF;
    tick(3);
    for (int i = 0; i < N; i++) begin
      total_cnt++;
      if (bcds[i] !== 4'd0 || load_bcds[i] !== 4'd0)
        $display("FAIL reset_digits[%0d]: got bcds=%0d load_bcds=%0d expected 0/0", i, bcds[i], load_bcds[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (cursor !== 3'd0 || load !== 1'b0)
      $display("FAIL reset_ctrl: got cursor=%0d load=%0b expected 0/0", cursor, load);
    else pass_cnt++;
    reset = 1'b0;
    tick(2);
    for (int i = 0; i < N; i++) exp_bcds[i] = 4'd0;
    exp_cursor = 0;
  endtask

  task automatic test_bounce();
    keys_n = ~M_INC; tick(3);
    keys_n = 4'hF;   tick(1);
    keys_n = ~M_INC; tick(3);
    keys_n = 4'hF;
    for (int c = 0; c < 12; c++) begin
      total_cnt++;
      if (bcds[0] !== 4'd0) $display("FAIL bounce c%0d: got bcds[0]=%0d expected 0", c, bcds[0]);
      else pass_cnt++;
      tick(1);
    end
  endtask

  task automatic test_increment_wrap();
    keys_n = ~M_INC;
    tick(LAT);
    total_cnt++;
    if (bcds[0] !== 4'd0) $display("FAIL inc_latency_early: got %0d expected 0", bcds[0]);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (bcds[0] !== 4'd1) $display("FAIL inc_latency_edge: got %0d expected 1", bcds[0]);
    else pass_cnt++;
    tick(10 - LAT - 1);
    keys_n = 4'hF;
    tick(10);
    exp_bcds[0] = 4'd1;
    for (int k = 2; k <= 10; k++) begin
      press(M_INC, 10, 10);
      exp_bcds[0] = bcd_t'(k % 10);
      total_cnt++;
      if (bcds[0] !== exp_bcds[0]) $display("FAIL inc_step%0d: got %0d expected %0d", k, bcds[0], exp_bcds[0]);
      else pass_cnt++;
    end
    total_cnt++;
    if (bcds[1] !== 4'd0) $display("FAIL inc_no_carry: got bcds[1]=%0d expected 0", bcds[1]);
    else pass_cnt++;
  endtask

  task automatic test_cursor_decrement();
    for (int k = 1; k <= N; k++) begin
      press(M_CUR, 10, 10);
      exp_cursor = k % N;
      total_cnt++;
      if (cursor !== 3'(exp_cursor)) $display("FAIL cursor_step%0d: got %0d expected %0d", k, cursor, exp_cursor);
      else pass_cnt++;
    end
    press(M_CUR, 10, 10);
    exp_cursor = 1;
    press(M_DEC, 10, 10);
    exp_bcds[1] = 4'd9;
    total_cnt++;
    if (bcds[1] !== 4'd9 || bcds[0] !== 4'd0 || cursor !== 3'd1)
      $display("FAIL dec_wrap: got bcds[1]=%0d bcds[0]=%0d cursor=%0d expected 9/0/1", bcds[1], bcds[0], cursor);
    else pass_cnt++;
  endtask

  task automatic test_commit();
    int loads;
    for (int i = 0; i < N; i++) set_digit(i, i + 1);
    for (int i = 0; i < N; i++) begin
      total_cnt++;
      if (bcds[i] !== exp_bcds[i]) $display("FAIL setup_digit[%0d]: got %0d expected %0d", i, bcds[i], exp_bcds[i]);
      else pass_cnt++;
    end
    loads  = 0;
    keys_n = ~M_COM;
    for (int c = 0; c < 40; c++) begin
      tick(1);
      if (load === 1'b1) loads++;
    end
    keys_n = 4'hF;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      if (load === 1'b1) loads++;
    end
    total_cnt++;
    if (loads != 1) $display("FAIL commit_load_count: got %0d expected 1", loads);
    else pass_cnt++;
    for (int i = 0; i < N; i++) begin
      total_cnt++;
      if (load_bcds[i] !== bcd_t'(i + 1) || bcds[i] !== exp_bcds[i])
        $display("FAIL commit_digit[%0d]: got load_bcds=%0d bcds=%0d expected %0d/%0d", i, load_bcds[i], bcds[i], i + 1, exp_bcds[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (cursor !== 3'(exp_cursor)) $display("FAIL commit_cursor: got %0d expected %0d", cursor, exp_cursor);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    press(M_INC | M_DEC, 10, 10);
    total_cnt++;
    if (bcds[7] !== exp_bcds[7]) $display("FAIL inc_dec_cancel: got %0d expected %0d", bcds[7], exp_bcds[7]);
    else pass_cnt++;
    set_digit(7, 5);
    for (int i = 0; i < N; i++) exp_load[i] = exp_bcds[i];
    press(M_COM | M_INC, 10, 10);
    exp_bcds[7] = 4'd6;
    total_cnt++;
    if (load_bcds[7] !== 4'd5 || bcds[7] !== 4'd6)
      $display("FAIL commit_with_inc: got load_bcds[7]=%0d bcds[7]=%0d expected 5/6", load_bcds[7], bcds[7]);
    else pass_cnt++;
    for (int i = 0; i < 7; i++) begin
      total_cnt++;
      if (load_bcds[i] !== exp_load[i]) $display("FAIL commit_with_inc_digit[%0d]: got %0d expected %0d", i, load_bcds[i], exp_load[i]);
      else pass_cnt++;
    end
    press(M_CUR | M_INC, 10, 10);
    exp_bcds[7] = 4'd7;
    exp_cursor  = 0;
    total_cnt++;
    if (bcds[7] !== 4'd7 || bcds[0] !== 4'd1 || cursor !== 3'd0)
      $display("FAIL cursor_with_inc: got bcds[7]=%0d bcds[0]=%0d cursor=%0d expected 7/1/0", bcds[7], bcds[0], cursor);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    keys_n = ~M_INC;
    tick(4);
    reset = 1'b1;
    tick(1);
    for (int i = 0; i < N; i++) begin
      total_cnt++;
      if (bcds[i] !== 4'd0 || load_bcds[i] !== 4'd0)
        $display("FAIL midreset_digits[%0d]: got bcds=%0d load_bcds=%0d expected 0/0", i, bcds[i], load_bcds[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (cursor !== 3'd0 || load !== 1'b0)
      $display("FAIL midreset_ctrl: got cursor=%0d load=%0b expected 0/0", cursor, load);
    else pass_cnt++;
    reset = 1'b0;
    tick(LAT);
    total_cnt++;
    if (bcds[0] !== 4'd0) $display("FAIL midreset_early: got %0d expected 0", bcds[0]);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (bcds[0] !== 4'd1) $display("FAIL midreset_press: got %0d expected 1", bcds[0]);
    else pass_cnt++;
    tick(20);
    total_cnt++;
    if (bcds[0] !== 4'd1 || bcds[1] !== 4'd0) $display("FAIL midreset_single: got bcds[0]=%0d bcds[1]=%0d expected 1/0", bcds[0], bcds[1]);
    else pass_cnt++;
    keys_n = 4'hF;
    tick(10);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_increment_wrap();
    test_cursor_decrement();
    test_commit();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
